// File: rtl/uart_pkg.sv
// Shared UART types, parity encodings and baud helper.
// Imported by the transmitter and its baud tick generator.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    function automatic int baud_divider(
        input longint clk_freq,
        input longint baud_rate
    );
        return int'(clk_freq / baud_rate);
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Producer-side valid/ready word handshake for the UART transmitter.
// master: tx_data, tx_valid out / tx_ready in; slave: the reverse.
interface uart_tx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period tick: one-cycle pulse every DIVIDER clocks after restart.
// Ports: clk, reset (sync, active high), restart in; tick out.
module uart_baud_tick #(
    parameter int DIVIDER = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);
    localparam int CW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIVIDER - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (restart || cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Count 0 lands on the first cycle after restart, so the
    // tick marks the last cycle of a full DIVIDER-clock period.
    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, LSB-first data, optional parity, stop bits.
// Ports: clk, reset, bus (slave handshake), tx_serial, tx_busy, tx_done.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQUENCY = 100_000_000,
    parameter int BAUD_RATE     = 115200,
    parameter int DATA_BITS     = 8,
    parameter int PARITY_MODE   = 0,
    parameter int STOP_BITS     = 1
) (
    input  logic     clk,
    input  logic     reset,
    uart_tx_if.slave bus,
    output logic     tx_serial,
    output logic     tx_busy,
    output logic     tx_done
);
    localparam int BAUD_DIVIDER = baud_divider(CLK_FREQUENCY, BAUD_RATE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    if (BAUD_DIVIDER < 2) begin : g_bad_baud
        $error("uart_tx: BAUD_DIVIDER must be at least 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end
    if (PARITY_MODE > 2) begin : g_bad_parity
        $error("uart_tx: PARITY_MODE must be 0, 1 or 2");
    end

    uart_tx_state_t       state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                 parity_q, parity_d;
    logic                 serial_q, serial_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic handshake;
    logic tick;

    // ready_q is high exactly in IDLE, so it doubles as the state qualifier.
    assign handshake = bus.tx_valid && ready_q;

    uart_baud_tick #(
        .DIVIDER(BAUD_DIVIDER)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .restart(handshake),
        .tick   (tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        parity_d  = parity_q;
        serial_d  = serial_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                serial_d = 1'b1;
                ready_d  = 1'b1;
                busy_d   = 1'b0;
                if (handshake) begin
                    state_d   = START;
                    shift_d   = bus.tx_data;
                    bit_cnt_d = '0;
                    parity_d  = (PARITY_MODE == PARITY_ODD) ?
                                ~(^bus.tx_data) : ^bus.tx_data;
                    serial_d  = 1'b0;
                    ready_d   = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                    serial_d  = shift_q[0];
                    shift_d   = shift_q >> 1;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
                        if (PARITY_MODE != PARITY_NONE) begin
                            state_d  = PARITY;
                            serial_d = parity_q;
                        end else begin
                            state_d  = STOP;
                            serial_d = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        serial_d  = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_d   = STOP;
                    bit_cnt_d = '0;
                    serial_d  = 1'b1;
                end
            end
            STOP: begin
                if (tick) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        state_d   = IDLE;
                        bit_cnt_d = '0;
                        serial_d  = 1'b1;
                        ready_d   = 1'b1;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                serial_d = 1'b1;
                ready_d  = 1'b1;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            parity_q  <= 1'b0;
            serial_q  <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            parity_q  <= parity_d;
            serial_q  <= serial_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.tx_ready = ready_q;
    assign tx_serial    = serial_q;
    assign tx_busy      = busy_q;
    assign tx_done      = done_q;

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Serial UART transmitter; the transmit counterpart of the team's UART receiver, sharing its baud and frame parameters. Accepts one parallel word per valid/ready handshake and shifts it out as a framed asynchronous character: start bit, LSB-first data, optional parity, then 1 or 2 stop bits. Sits between the system-side producer (FIFO or register block) and the tx pad.

Parameters:
CLK_FREQUENCY, 100_000_000, system clock frequency in Hz
BAUD_RATE, 115200, line rate in bits/s
DATA_BITS, 8, data bits per frame (5..9)
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high reset
tx_data  in  DATA_BITS  word to transmit, sampled only on handshake
tx_valid  in  1  producer has a word; must hold tx_data stable until accepted
tx_ready  out  1  high only in IDLE; handshake = tx_valid && tx_ready at posedge
tx_serial  out  1  serial line, idle high
tx_busy  out  1  high from the cycle after the handshake until the frame ends
tx_done  out  1  one-cycle pulse when the last stop bit completes

Behaviour:
- BAUD_DIVIDER = CLK_FREQUENCY/BAUD_RATE, integer-truncated. Each line bit is held exactly BAUD_DIVIDER clocks.
- Elaboration error if BAUD_DIVIDER < 2, STOP_BITS is not 1 or 2, or PARITY_MODE > 2.
- Frame length FRAME_BITS = 1 + DATA_BITS + (PARITY_MODE != 0) + STOP_BITS.
- All outputs are registered.
- Reset values: tx_serial = 1, tx_ready = 1, tx_busy = 0, tx_done = 0. State = IDLE; counters and shift register cleared.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE -> START on handshake. tx_data is latched into the shift register. Parity is computed from the latched word: even = XOR of the data bits; odd = inverted XOR.
- Latency: tx_serial falls on the first cycle after the handshake edge.
- START -> DATA after BAUD_DIVIDER cycles.
- DATA shifts out LSB first. After DATA_BITS bit periods, go to PARITY if PARITY_MODE != 0, else to STOP.
- PARITY -> STOP after one bit period.
- STOP drives 1 for STOP_BITS bit periods, then goes to IDLE. In that same IDLE cycle: tx_done = 1, tx_ready = 1, tx_busy = 0.
- Back-to-back: tx_valid held high is accepted in the first IDLE cycle. The minimum high time between frames is STOP_BITS*BAUD_DIVIDER + 1 clocks.
- tx_valid and tx_data changes while not in IDLE are ignored. No queuing, no effect on the frame in flight.
- Reset mid-frame: the frame is aborted. tx_serial = 1 in the cycle after the reset edge, no tx_done pulse, tx_ready = 1. No handshake is taken while reset is high.
- Baud counter restarts at 0 at each handshake, so there is no phase carry-over between frames.
- Baud counter width is $clog2(BAUD_DIVIDER). Bit counter width is $clog2(DATA_BITS+1); it wraps to 0 on entry to each state.

Decomposition:
- Package uart_pkg:
  - uart_tx_state_t enum (IDLE, START, DATA, PARITY, STOP)
  - PARITY_NONE/EVEN/ODD constants
  - function baud_divider(clk_freq, baud_rate), shared with the receiver
- Sub-module uart_baud_tick:
  - parameter DIVIDER
  - inputs clk, reset, restart; output tick, a one-cycle pulse every DIVIDER clocks after restart
  - the transmitter advances bit periods on tick

Test Plan (CLK_FREQUENCY=1_000_000, BAUD_RATE=100_000, so BAUD_DIVIDER = 10):
1. 8N1, send 0xA5 -> line low 10 cycles, then bits 1,0,1,0,0,1,0,1 (10 cycles each), then high 10; tx_done pulses exactly 100 cycles after tx_serial falls, once.
2. PARITY_MODE=1, send 0x07 -> parity bit = 1; PARITY_MODE=2, send 0x07 -> parity bit = 0; done 110 cycles after start edge.
3. tx_valid held high, 0x00 then 0xFF -> second start falls 101 cycles after first start; second frame data bits all 1.
4. Reset asserted during data bit 3 of 0x55 -> tx_serial = 1 next cycle, tx_busy = 0, no tx_done; following frame 0x3C transmits correctly.
5. After accepting 0x81, toggle tx_valid and change tx_data to 0x7E mid-frame -> line still carries 0x81, tx_ready stays 0 until done.
6. STOP_BITS=2, send 0xFF -> stop high 20 cycles, tx_done 110 cycles after start edge.
